// File: rtl/life_step_if.sv
// Bus between the Life step engine, the frame buffers and the generation synchronizer.
// Start/done: logic_start_in is a one-cycle request, accepted only while the engine is not busy.
// logic_done_out is a level that stays high until the next accepted start.
// Reads return data one cycle after the address. Each wr_en_out cycle carries one complete cell write.
interface life_step_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  logic_start_in;
    logic                  logic_done_out;
    logic                  busy_out;
    logic [ADDR_WIDTH-1:0] rd_addr_out;
    logic                  rd_data_in;
    logic [ADDR_WIDTH-1:0] wr_addr_out;
    logic                  wr_data_out;
    logic                  wr_en_out;
    logic [2:0]            state_dbg;

    modport master (
        input  logic_start_in, rd_data_in,
        output logic_done_out, busy_out, rd_addr_out, wr_addr_out, wr_data_out, wr_en_out,
        state_dbg
    );

    modport slave (
        output logic_start_in, rd_data_in,
        input  logic_done_out, busy_out, rd_addr_out, wr_addr_out, wr_data_out, wr_en_out,
        state_dbg
    );
endinterface

// File: rtl/life_step_engine.sv
// Conway B3/S23 generation sweep: 9 neighbour reads per cell, one back-buffer write per cell.
// Optional build macro LIFE_TORUS_EN: toroidal board (otherwise off-board neighbours count as dead).
module life_step_engine #(
    parameter int BOARD_W    = 64,
    parameter int BOARD_H    = 48,
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk_in,
    input  logic        rst_in,
    life_step_if.master bus
);
    localparam int XW = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
    localparam int YW = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(BOARD_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(BOARD_H - 1);
    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0] Y_ONE = YW'(1);
    localparam logic [ADDR_WIDTH-1:0] W_A = ADDR_WIDTH'(BOARD_W);
`ifdef LIFE_TORUS_EN
    localparam logic TORUS = 1'b1;
`else
    localparam logic TORUS = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, FETCH, LAST, WRITE, DONE} state_e;

    state_e                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [3:0]            k_q, k_d;
    logic [3:0]            k_dly_q, k_dly_d;
    logic [3:0]            acc_q, acc_d;
    logic                  self_q, self_d;
    logic                  valid_q, valid_d;
    logic                  mask_q, mask_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic [1:0]            kx, ky;
    logic [XW-1:0]         nx;
    logic [YW-1:0]         ny;
    logic                  off_board;
    logic [ADDR_WIDTH-1:0] nbr_addr;
    logic [ADDR_WIDTH-1:0] cell_addr;
    logic                  next_alive;

    // Neighbour coordinate is always wrapped so the read address stays on the board;
    // off_board remembers whether the wrap happened so the dead-border build can mask it.
    always_comb begin
        kx        = 2'(k_q % 4'd3);
        ky        = 2'(k_q / 4'd3);
        nx        = x_q;
        ny        = y_q;
        off_board = 1'b0;
        if (kx == 2'd0) begin
            if (x_q == '0) begin
                nx        = X_MAX;
                off_board = 1'b1;
            end else begin
                nx = x_q - X_ONE;
            end
        end else if (kx == 2'd2) begin
            if (x_q == X_MAX) begin
                nx        = '0;
                off_board = 1'b1;
            end else begin
                nx = x_q + X_ONE;
            end
        end
        if (ky == 2'd0) begin
            if (y_q == '0) begin
                ny        = Y_MAX;
                off_board = 1'b1;
            end else begin
                ny = y_q - Y_ONE;
            end
        end else if (ky == 2'd2) begin
            if (y_q == Y_MAX) begin
                ny        = '0;
                off_board = 1'b1;
            end else begin
                ny = y_q + Y_ONE;
            end
        end
    end

    assign nbr_addr   = ADDR_WIDTH'(ny) * W_A + ADDR_WIDTH'(nx);
    assign cell_addr  = ADDR_WIDTH'(y_q) * W_A + ADDR_WIDTH'(x_q);
    assign next_alive = (acc_q == 4'd3) | (self_q & (acc_q == 4'd2));

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        k_d       = k_q;
        k_dly_d   = k_dly_q;
        acc_d     = acc_q;
        self_d    = self_q;
        valid_d   = 1'b0;
        mask_d    = mask_q;
        rd_addr_d = rd_addr_q;

        // Read data lags its address by one cycle; k_dly_q tags which neighbour it is.
        if (valid_q) begin
            if (k_dly_q == 4'd4) begin
                self_d = bus.rd_data_in;
            end else begin
                acc_d = acc_q + {3'b000, bus.rd_data_in & mask_q};
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.logic_start_in) begin
                    state_d = FETCH;
                    x_d     = '0;
                    y_d     = '0;
                    k_d     = 4'd0;
                    acc_d   = 4'd0;
                    self_d  = 1'b0;
                end
            end
            FETCH: begin
                valid_d   = 1'b1;
                k_dly_d   = k_q;
                mask_d    = TORUS | ~off_board;
                rd_addr_d = nbr_addr;
                if (k_q == 4'd8) begin
                    state_d = LAST;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            LAST: state_d = WRITE;
            WRITE: begin
                if ((x_q == X_MAX) && (y_q == Y_MAX)) begin
                    state_d = DONE;
                end else begin
                    state_d = FETCH;
                    k_d     = 4'd0;
                    acc_d   = 4'd0;
                    self_d  = 1'b0;
                    if (x_q == X_MAX) begin
                        x_d = '0;
                        y_d = y_q + Y_ONE;
                    end else begin
                        x_d = x_q + X_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            k_q       <= 4'd0;
            k_dly_q   <= 4'd0;
            acc_q     <= 4'd0;
            self_q    <= 1'b0;
            valid_q   <= 1'b0;
            mask_q    <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            k_q       <= k_d;
            k_dly_q   <= k_dly_d;
            acc_q     <= acc_d;
            self_q    <= self_d;
            valid_q   <= valid_d;
            mask_q    <= mask_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign bus.rd_addr_out    = (state_q == FETCH) ? nbr_addr : rd_addr_q;
    assign bus.wr_en_out      = (state_q == WRITE);
    assign bus.wr_addr_out    = (state_q == WRITE) ? cell_addr : '0;
    assign bus.wr_data_out    = (state_q == WRITE) & next_alive;
    assign bus.busy_out       = (state_q == FETCH) | (state_q == LAST) | (state_q == WRITE);
    assign bus.logic_done_out = (state_q == DONE);
    assign bus.state_dbg      = state_q;
endmodule

// File: doc/life_step_engine.md
Name: life_step_engine

Overview:
Responder side of the generation handshake driven by the synchronizer. On a logic_start pulse it sweeps the whole board in raster order, reading the current (front) buffer and applying the Conway B3/S23 rule. It writes each next-state cell into the back buffer, then raises logic_done. Buffer selection and swapping are handled outside this block; it sees only one read port and one write port.

Parameters:
BOARD_W, 64, board width in cells
BOARD_H, 48, board height in cells
ADDR_WIDTH, 12, cell address width; must satisfy 2^ADDR_WIDTH >= BOARD_W*BOARD_H

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-low reset
logic_start_in  input  1  one-cycle request to compute the next generation
logic_done_out  output  1  generation complete; level signal
busy_out  output  1  sweep in progress
rd_addr_out  output  ADDR_WIDTH  front-buffer read address
rd_data_in  input  1  front-buffer cell, valid one cycle after rd_addr_out
wr_addr_out  output  ADDR_WIDTH  back-buffer write address
wr_data_out  output  1  next-state cell
wr_en_out  output  1  back-buffer write strobe

Behaviour:
- Reset: rst_in low asynchronously forces state IDLE and clears x, y, k and the accumulator.
- Reset values: logic_done_out=0, busy_out=0, wr_en_out=0, rd_addr_out=0, wr_addr_out=0, wr_data_out=0.
- Reset mid-sweep: abandons the sweep; no further writes; logic_done_out stays 0.
- Address map: addr = y*BOARD_W + x. Cells are visited in raster order, x fastest.
- States: IDLE, FETCH, LAST, WRITE, DONE.
- IDLE -> FETCH on logic_start_in=1. Action: x=y=0, k=0, acc=0, busy_out=1.
- FETCH: k steps 0..8, one read per cycle. Neighbour offset: dx=(k%3)-1, dy=(k/3)-1; rd_addr_out is the address of (x+dx, y+dy). At k=8 go to LAST.
- Accumulation: the delayed strobe (rd issued last cycle, k_d) adds rd_data_in to acc for k_d != 4. k_d=4 is latched as self.
- LAST: one cycle; captures the data for k=8.
- WRITE: one cycle; wr_en_out=1, wr_addr_out = addr(x,y), wr_data_out = (acc==3) | (self & acc==2).
  - acc is 4 bits, range 0..8.
  - Then advance x; on x==BOARD_W-1, wrap x to 0 and increment y.
  - Last cell (BOARD_W-1, BOARD_H-1) -> DONE; otherwise -> FETCH with k=0, acc=0.
- Cell cost: exactly 11 cycles. Sweep: BOARD_W*BOARD_H*11 cycles from the first FETCH cycle to the last WRITE cycle inclusive.
- DONE: busy_out=0, logic_done_out=1.
  - logic_done_out stays high until the next logic_start_in, then clears in the same edge that enters FETCH.
  - DONE accepts logic_start_in exactly like IDLE.
- logic_start_in while busy_out=1 is ignored and is not queued.
- wr_en_out is high only in WRITE. rd_addr_out holds its last value outside FETCH.
- Off-board neighbours: see Optional Feature. rd_addr_out always carries an in-range address.

Optional Feature:
LIFE_TORUS_EN
- Defined: neighbour coordinates wrap modulo BOARD_W and BOARD_H (toroidal board); every neighbour read counts.
- Undefined: coordinates are still wrapped for rd_addr_out, but neighbours with x+dx or y+dy outside the board are masked to 0 in acc (dead border).
- Cycle timing is identical in both builds.

Test Plan:
1. Reset: drive rst_in low mid-FETCH -> all outputs 0 immediately and no wr_en_out afterwards. Release reset, then logic_start_in -> full sweep runs normally.
2. Blinker, BOARD_W=BOARD_H=5: front alive at (1,2),(2,2),(3,2); pulse start -> back alive at (2,1),(2,2),(2,3) only. logic_done_out rises after 275 sweep cycles; 25 wr_en_out pulses, addresses 0..24 in order.
3. Block still-life, 4x4: alive (1,1),(2,1),(1,2),(2,2) -> back identical; all other 12 cells written 0.
4. Torus corner, 4x4: alive (0,0),(3,0),(0,3).
   - With LIFE_TORUS_EN: (3,3) born, (0,0),(3,0),(0,3) survive (2 neighbours each).
   - Without it: all four cells dead.
5. Handshake: pulse logic_start_in again at cycle 50 of a sweep -> ignored, single done. Next start while done is high -> logic_done_out falls on that edge and the second sweep completes.
6. Empty board, 5x5 -> every write has wr_data_out=0. busy_out is high for exactly 275 cycles.
